// File: rtl/mem_pkg.sv
// Shared definitions for the L1 miss arbiter: FSM state encoding,
// requester IDs and refill line geometry.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int LINE_SIZE    = 512;
    localparam int OFFSET_WIDTH = 6;

endpackage

// File: rtl/miss_pend_slot.sv
// One outstanding-miss slot: holds a pending bit plus the captured address,
// and flags misses that arrive while the slot is already occupied.
module miss_pend_slot #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_clear,
    output logic                  o_pend,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_drop
);

    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_addr;

    // A miss landing in the same cycle the slot is released re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_addr <= '0;
        end else if (i_set && (!r_pend || i_clear)) begin
            r_pend <= 1'b1;
            r_addr <= i_addr;
        end else if (i_clear) begin
            r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_addr = r_addr;
    assign o_drop = i_set && r_pend && !i_clear;

endmodule

// File: rtl/l1_miss_arbiter.sv
// Round-robin arbiter sharing one memory refill port between the Icache and
// Dcache miss paths, with a single outstanding line read at a time.
module l1_miss_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int LINE_SIZE    = mem_pkg::LINE_SIZE,
    parameter int OFFSET_WIDTH = mem_pkg::OFFSET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_miss_valid_i,
    input  logic [ADDR_WIDTH-1:0] icache_miss_addr_i,
    input  logic                  dcache_miss_valid_i,
    input  logic [ADDR_WIDTH-1:0] dcache_miss_addr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic                  mem_req_id_o,
    input  logic                  mem_resp_valid_i,
    input  logic [LINE_SIZE-1:0]  mem_resp_data_i,
    output logic                  refill_icache_valid_o,
    output logic [LINE_SIZE-1:0]  refill_icache_data_o,
    output logic                  refill_dcache_valid_o,
    output logic [LINE_SIZE-1:0]  refill_dcache_data_o,
    output logic                  err_o
);

    import mem_pkg::*;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_req_id;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic                  r_last_grant;
    logic [LINE_SIZE-1:0]  r_line;
    logic                  r_err;

    logic [1:0]            w_miss_valid;
    logic [1:0]            w_pend;
    logic [1:0]            w_clear;
    logic [1:0]            w_drop;
    logic [ADDR_WIDTH-1:0] w_miss_addr [2];
    logic [ADDR_WIDTH-1:0] w_pend_addr [2];
    logic                  w_grant_id;
    logic [ADDR_WIDTH-1:0] w_grant_addr;
    logic                  w_grant;

    // Slot index equals requester ID: 0 = Icache, 1 = Dcache.
    assign w_miss_valid   = {dcache_miss_valid_i, icache_miss_valid_i};
    assign w_miss_addr[0] = icache_miss_addr_i;
    assign w_miss_addr[1] = dcache_miss_addr_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign w_clear[gi] = (r_state == ST_RESP) && (int'(r_req_id) == gi);

            miss_pend_slot #(
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_set   (w_miss_valid[gi]),
                .i_addr  (w_miss_addr[gi]),
                .i_clear (w_clear[gi]),
                .o_pend  (w_pend[gi]),
                .o_addr  (w_pend_addr[gi]),
                .o_drop  (w_drop[gi])
            );
        end
    endgenerate

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_grant_id = REQ_DCACHE;
        if (&w_pend) begin
            w_grant_id = ~r_last_grant;
        end else if (w_pend[0]) begin
            w_grant_id = REQ_ICACHE;
        end
    end

    assign w_grant_addr = w_grant_id ? w_pend_addr[1] : w_pend_addr[0];
    assign w_grant      = (r_state == ST_IDLE) && (|w_pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (|w_pend)          w_state_next = ST_REQ;
            ST_REQ:  if (mem_req_ready_i)  w_state_next = ST_WAIT;
            ST_WAIT: if (mem_resp_valid_i) w_state_next = ST_RESP;
            ST_RESP:                       w_state_next = ST_IDLE;
            default:                       w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid_o       = 1'b0;
        refill_icache_valid_o = 1'b0;
        refill_dcache_valid_o = 1'b0;
        case (r_state)
            ST_REQ:  mem_req_valid_o = 1'b1;
            ST_RESP: begin
                refill_icache_valid_o = (r_req_id == REQ_ICACHE);
                refill_dcache_valid_o = (r_req_id == REQ_DCACHE);
            end
            default: ;
        endcase
    end

    // Request regs hold the line-aligned address so it stays stable in REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_id     <= REQ_ICACHE;
            r_req_addr   <= '0;
            r_last_grant <= REQ_DCACHE;
            r_line       <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_grant) begin
                r_req_id     <= w_grant_id;
                r_req_addr   <= {w_grant_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                r_last_grant <= w_grant_id;
            end
            if ((r_state == ST_WAIT) && mem_resp_valid_i) begin
                r_line <= mem_resp_data_i;
            end
            if ((|w_drop) || (mem_resp_valid_i && (r_state != ST_WAIT))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req_addr_o       = r_req_addr;
    assign mem_req_id_o         = r_req_id;
    assign refill_icache_data_o = r_line;
    assign refill_dcache_data_o = r_line;
    assign err_o                = r_err;

endmodule

// File: tb/tb_l1_miss_arbiter.sv
// Directed self-checking bench for l1_miss_arbiter.
module tb_l1_miss_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_v, dc_v;
    logic [63:0]  ic_a, dc_a;
    logic         req_v, req_rdy, req_id;
    logic [63:0]  req_a;
    logic         resp_v;
    logic [511:0] resp_d;
    logic         ref_i_v, ref_d_v, err;
    logic [511:0] ref_i_d, ref_d_d;

    int n_cmp  = 0;
    int n_fail = 0;

    l1_miss_arbiter #(
        .ADDR_WIDTH   (64),
        .LINE_SIZE    (512),
        .OFFSET_WIDTH (6)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .icache_miss_valid_i   (ic_v),
        .icache_miss_addr_i    (ic_a),
        .dcache_miss_valid_i   (dc_v),
        .dcache_miss_addr_i    (dc_a),
        .mem_req_valid_o       (req_v),
        .mem_req_ready_i       (req_rdy),
        .mem_req_addr_o        (req_a),
        .mem_req_id_o          (req_id),
        .mem_resp_valid_i      (resp_v),
        .mem_resp_data_i       (resp_d),
        .refill_icache_valid_o (ref_i_v),
        .refill_icache_data_o  (ref_i_d),
        .refill_dcache_valid_o (ref_d_v),
        .refill_dcache_data_o  (ref_d_d),
        .err_o                 (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ic_v = 1'b0; dc_v = 1'b0; ic_a = '0; dc_a = '0;
        req_rdy = 1'b0; resp_v = 1'b0; resp_d = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ic_v = 1'b0; dc_v = 1'b0; req_rdy = 1'b0; resp_v = 1'b0;
        tick(); tick();
        n_cmp++; if (req_v !== 1'b0)  begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", req_v); end
        n_cmp++; if (req_a !== 64'h0) begin n_fail++; $display("FAIL rst_req_addr: got %h want 0", req_a); end
        n_cmp++; if (req_id !== 1'b0) begin n_fail++; $display("FAIL rst_req_id: got %b want 0", req_id); end
        n_cmp++; if ({ref_i_v, ref_d_v} !== 2'b00) begin n_fail++; $display("FAIL rst_refill_valid: got %b want 00", {ref_i_v, ref_d_v}); end
        n_cmp++; if (ref_i_d !== 512'h0 || ref_d_d !== 512'h0) begin n_fail++; $display("FAIL rst_refill_data: got nonzero want 0"); end
        n_cmp++; if (err !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_single_icache();
        logic [511:0] d;
        d = {64{8'hA5}};
        do_reset();
        req_rdy = 1'b1;
        ic_v = 1'b1; ic_a = 64'h8000_1234;                 // cycle 0
        tick(); ic_v = 1'b0;                               // cycle 1
        n_cmp++; if (req_v !== 1'b0) begin n_fail++; $display("FAIL t1_req_early: got %b want 0", req_v); end
        tick();                                            // cycle 2
        n_cmp++; if (req_v !== 1'b1) begin n_fail++; $display("FAIL t1_req_valid: got %b want 1", req_v); end
        n_cmp++; if (req_a !== 64'h8000_1200) begin n_fail++; $display("FAIL t1_req_addr: got %h want 8000_1200", req_a); end
        n_cmp++; if (req_id !== 1'b0) begin n_fail++; $display("FAIL t1_req_id: got %b want 0", req_id); end
        for (int c = 3; c <= 5; c++) begin
            tick();
            n_cmp++; if (req_v !== 1'b0 || ref_i_v !== 1'b0) begin n_fail++; $display("FAIL t1_idle_c%0d: got req=%b ref=%b want 0 0", c, req_v, ref_i_v); end
        end
        resp_v = 1'b1; resp_d = d;                         // response in cycle 5
        tick(); resp_v = 1'b0;                             // cycle 6
        n_cmp++; if (ref_i_v !== 1'b1) begin n_fail++; $display("FAIL t1_refill_i: got %b want 1", ref_i_v); end
        n_cmp++; if (ref_d_v !== 1'b0) begin n_fail++; $display("FAIL t1_refill_d: got %b want 0", ref_d_v); end
        n_cmp++; if (ref_i_d !== d) begin n_fail++; $display("FAIL t1_refill_data: got %h want %h", ref_i_d, d); end
        tick();                                            // cycle 7
        n_cmp++; if (ref_i_v !== 1'b0) begin n_fail++; $display("FAIL t1_refill_pulse: got %b want 0", ref_i_v); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b want 0", err); end
        $display("txn icache 8000_1234 -> refill cycle 6");
    endtask

    task automatic test_tie_round_robin();
        logic [511:0] d1, d2, d3;
        d1 = {16{32'h1111_0001}}; d2 = {16{32'h2222_0002}}; d3 = {16{32'h3333_0003}};
        do_reset();
        req_rdy = 1'b1;
        ic_v = 1'b1; ic_a = 64'h1000_0040; dc_v = 1'b1; dc_a = 64'h2000_0088;  // c0
        tick(); ic_v = 1'b0; dc_v = 1'b0;                  // c1
        tick();                                            // c2
        n_cmp++; if (req_id !== 1'b0 || req_a !== 64'h1000_0040) begin n_fail++; $display("FAIL t2_first_grant: got id=%b addr=%h want 0 1000_0040", req_id, req_a); end
        tick(); resp_v = 1'b1; resp_d = d1;                // c3
        tick(); resp_v = 1'b0;                             // c4 RESP icache, re-arm icache
        n_cmp++; if (ref_i_v !== 1'b1 || ref_d_v !== 1'b0) begin n_fail++; $display("FAIL t2_refill1: got i=%b d=%b want 1 0", ref_i_v, ref_d_v); end
        ic_v = 1'b1; ic_a = 64'h1000_0100;
        tick(); ic_v = 1'b0;                               // c5
        n_cmp++; if (req_v !== 1'b0) begin n_fail++; $display("FAIL t2_gap: got %b want 0", req_v); end
        tick();                                            // c6
        n_cmp++; if (req_v !== 1'b1 || req_id !== 1'b1 || req_a !== 64'h2000_0080) begin n_fail++; $display("FAIL t2_tie_dcache: got v=%b id=%b addr=%h want 1 1 2000_0080", req_v, req_id, req_a); end
        tick(); resp_v = 1'b1; resp_d = d2;                // c7
        tick(); resp_v = 1'b0;                             // c8
        n_cmp++; if (ref_d_v !== 1'b1 || ref_i_v !== 1'b0 || ref_d_d !== d2) begin n_fail++; $display("FAIL t2_refill2: got i=%b d=%b want 0 1 with line", ref_i_v, ref_d_v); end
        tick();                                            // c9
        tick();                                            // c10
        n_cmp++; if (req_v !== 1'b1 || req_id !== 1'b0 || req_a !== 64'h1000_0100) begin n_fail++; $display("FAIL t2_rearm: got v=%b id=%b addr=%h want 1 0 1000_0100", req_v, req_id, req_a); end
        tick(); resp_v = 1'b1; resp_d = d3;                // c11
        tick(); resp_v = 1'b0;                             // c12
        n_cmp++; if (ref_i_v !== 1'b1 || ref_i_d !== d3) begin n_fail++; $display("FAIL t2_refill3: got i=%b want 1 with line", ref_i_v); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL t2_err: got %b want 0", err); end
        $display("txn tie: icache, dcache, icache(re-armed)");
    endtask

    task automatic test_backpressure();
        do_reset();
        req_rdy = 1'b0;
        dc_v = 1'b1; dc_a = 64'h3000_07FF;                 // c0
        tick(); dc_v = 1'b0;                               // c1
        tick();                                            // c2
        for (int c = 2; c < 12; c++) begin
            n_cmp++;
            if (req_v !== 1'b1 || req_id !== 1'b1 || req_a !== 64'h3000_07C0) begin
                n_fail++; $display("FAIL t3_hold_c%0d: got v=%b id=%b addr=%h want 1 1 3000_07C0", c, req_v, req_id, req_a);
            end
            tick();
        end
        req_rdy = 1'b1;                                    // c12
        n_cmp++; if (req_v !== 1'b1) begin n_fail++; $display("FAIL t3_ready_cycle: got %b want 1", req_v); end
        tick(); req_rdy = 1'b0;                            // c13 WAIT
        n_cmp++; if (req_v !== 1'b0) begin n_fail++; $display("FAIL t3_wait: got %b want 0", req_v); end
        resp_v = 1'b1; resp_d = {8{64'hDEAD_BEEF_0000_0007}};
        tick(); resp_v = 1'b0;                             // c14
        n_cmp++; if (ref_d_v !== 1'b1 || ref_i_v !== 1'b0) begin n_fail++; $display("FAIL t3_refill: got i=%b d=%b want 0 1", ref_i_v, ref_d_v); end
        $display("txn dcache 3000_07FF backpressured 10 cycles");
    endtask

    task automatic test_drop();
        int refills;
        do_reset();
        req_rdy = 1'b1;
        ic_v = 1'b1; ic_a = 64'h4000_0000;                 // c0
        tick(); ic_a = 64'h5000_0000;                      // c1: second miss while pending
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL t4_err_early: got %b want 0", err); end
        tick(); ic_v = 1'b0;                               // c2
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL t4_err_set: got %b want 1", err); end
        n_cmp++; if (req_a !== 64'h4000_0000) begin n_fail++; $display("FAIL t4_orig_addr: got %h want 4000_0000", req_a); end
        tick(); resp_v = 1'b1; resp_d = {64{8'h5A}};       // c3
        refills = 0;
        for (int c = 4; c < 10; c++) begin
            tick(); resp_v = 1'b0;
            if (ref_i_v === 1'b1) refills++;
        end
        n_cmp++; if (refills != 1) begin n_fail++; $display("FAIL t4_refill_count: got %0d want 1", refills); end
        n_cmp++; if (req_v !== 1'b0) begin n_fail++; $display("FAIL t4_no_second_req: got %b want 0", req_v); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL t4_err_sticky: got %b want 1", err); end
        $display("txn icache 4000_0000 with dropped second miss");
    endtask

    task automatic test_unexpected_resp();
        do_reset();
        resp_v = 1'b1; resp_d = {64{8'hFF}};               // c0 response in IDLE
        tick(); resp_v = 1'b0;                             // c1
        n_cmp++; if ({ref_i_v, ref_d_v} !== 2'b00) begin n_fail++; $display("FAIL t5_idle_refill: got %b want 00", {ref_i_v, ref_d_v}); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL t5_idle_err: got %b want 1", err); end
        do_reset();
        req_rdy = 1'b1;
        ic_v = 1'b1; ic_a = 64'h6000_0040;                 // c0
        tick(); ic_v = 1'b0;                               // c1
        tick();                                            // c2
        tick(); rst = 1'b1;                                // c3 WAIT, reset
        tick(); rst = 1'b0;                                // c4
        n_cmp++; if (req_v !== 1'b0 || req_a !== 64'h0 || req_id !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL t5_midreset: got v=%b addr=%h id=%b err=%b want all 0", req_v, req_a, req_id, err); end
        resp_v = 1'b1; resp_d = {64{8'h3C}};
        tick(); resp_v = 1'b0;                             // c5
        n_cmp++; if ({ref_i_v, ref_d_v} !== 2'b00 || ref_i_d !== 512'h0) begin n_fail++; $display("FAIL t5_late_refill: got %b want 00 and zero line", {ref_i_v, ref_d_v}); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL t5_late_err: got %b want 1", err); end
        tick();                                            // c6
        n_cmp++; if (req_v !== 1'b0) begin n_fail++; $display("FAIL t5_abandoned: got %b want 0", req_v); end
        $display("txn unexpected responses (idle, after reset)");
    endtask

    initial begin
        test_reset();
        test_single_icache();
        test_tie_round_robin();
        test_backpressure();
        test_drop();
        test_reset();
        test_unexpected_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
